// File: rtl/seven_seg_scan_driver.sv
// ----------------------------------------------------------------------------
// seven_seg_scan_driver
//
// Time-multiplexed driver for an N-digit common-anode seven-segment display.
//
// Digit codes and decimal-point flags are captured into a shadow buffer on
// i_load. They move to the displayed (active) buffer only at a frame boundary,
// so a partially drawn frame never mixes old and new values.
//
// Each digit stays lit for REFRESH_DIV clock cycles. A frame is
// NUM_DIGITS * REFRESH_DIV cycles long.
//
// Optional feature: define SEVEN_SEG_HEX_DIGITS_EN to show codes 10-15 as the
// hex glyphs A b C d E F. Without it, those codes are blank.
//
// Ports:
//   i_clk          system clock
//   i_rst          asynchronous active-high reset
//   i_load         one-cycle strobe; captures i_digits_in / i_dp_in to shadow
//   i_digits_in    packed 4-bit codes, digit k at [4k+3:4k], digit 0 rightmost
//   i_dp_in        decimal point per digit (1 = lit)
//   i_lz_suppress  level; 1 = blank leading zeros (not buffered)
//   o_seg_out      active-low segments {dp,g,f,e,d,c,b,a}, registered
//   o_an_out       active-low anode enables, registered
//   o_scan_done    one-cycle pulse per completed frame
// ----------------------------------------------------------------------------
module seven_seg_scan_driver #(
    parameter int unsigned NUM_DIGITS  = 4,
    parameter int unsigned REFRESH_DIV = 50000
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_load,
    input  logic [4*NUM_DIGITS-1:0] i_digits_in,
    input  logic [NUM_DIGITS-1:0]   i_dp_in,
    input  logic                    i_lz_suppress,
    output logic [7:0]              o_seg_out,
    output logic [NUM_DIGITS-1:0]   o_an_out,
    output logic                    o_scan_done
);

    // A single-digit build still needs a 1-bit index register.
    localparam int unsigned IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned PRESC_W = $clog2(REFRESH_DIV);

    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [PRESC_W-1:0]      r_presc;
    logic [IDX_W-1:0]        r_idx;
    logic [4*NUM_DIGITS-1:0] r_shadow_digits;
    logic [NUM_DIGITS-1:0]   r_shadow_dp;
    logic                    r_pending;
    logic [4*NUM_DIGITS-1:0] r_active_digits;
    logic [NUM_DIGITS-1:0]   r_active_dp;
    logic [7:0]              r_seg;
    logic [NUM_DIGITS-1:0]   r_an;
    logic                    r_scan_done;

    // ------------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------------
    logic                  w_presc_tc;
    logic                  w_frame_end;
    logic [NUM_DIGITS-1:0] w_lz_mask;
    logic                  w_upper_zero;
    logic [3:0]            w_cur_code;
    logic                  w_cur_dp;
    logic                  w_cur_lz;
    logic [6:0]            w_cur_glyph;
    logic [7:0]            w_seg_next;
    logic [NUM_DIGITS-1:0] w_an_next;

    // ------------------------------------------------------------------------
    // Glyph lookup, active-low {g,f,e,d,c,b,a}
    // ------------------------------------------------------------------------
    function automatic logic [6:0] f_encode(input logic [3:0] code);
        logic [6:0] glyph;
        case (code)
            4'd0:    glyph = 7'h40;
            4'd1:    glyph = 7'h79;
            4'd2:    glyph = 7'h24;
            4'd3:    glyph = 7'h30;
            4'd4:    glyph = 7'h19;
            4'd5:    glyph = 7'h12;
            4'd6:    glyph = 7'h02;
            4'd7:    glyph = 7'h78;
            4'd8:    glyph = 7'h00;
            4'd9:    glyph = 7'h10;
`ifdef SEVEN_SEG_HEX_DIGITS_EN
            4'd10:   glyph = 7'h08;
            4'd11:   glyph = 7'h03;
            4'd12:   glyph = 7'h46;
            4'd13:   glyph = 7'h21;
            4'd14:   glyph = 7'h06;
            4'd15:   glyph = 7'h0E;
`endif
            default: glyph = SEG_BLANK;
        endcase
        return glyph;
    endfunction

    // ------------------------------------------------------------------------
    // Scan timing
    // ------------------------------------------------------------------------
    assign w_presc_tc  = (r_presc == PRESC_LAST);
    assign w_frame_end = w_presc_tc && (r_idx == IDX_LAST);

    // ------------------------------------------------------------------------
    // Leading-zero mask: bit k is set when active digits k..NUM_DIGITS-1 are
    // all code 0. Digit 0 is never masked, so an all-zero value shows "0".
    // Codes 10-15 count as nonzero whether or not they have a glyph.
    // ------------------------------------------------------------------------
    always_comb begin
        w_lz_mask    = '0;
        w_upper_zero = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            w_upper_zero = w_upper_zero && (r_active_digits[4*k +: 4] == 4'd0);
            w_lz_mask[k] = w_upper_zero;
        end
    end

    // ------------------------------------------------------------------------
    // Select the digit at the current scan index and build the next outputs
    // ------------------------------------------------------------------------
    always_comb begin
        w_cur_code = 4'd0;
        w_cur_dp   = 1'b0;
        w_cur_lz   = 1'b0;
        w_an_next  = '1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (r_idx == IDX_W'(k)) begin
                w_cur_code   = r_active_digits[4*k +: 4];
                w_cur_dp     = r_active_dp[k];
                w_cur_lz     = w_lz_mask[k];
                w_an_next[k] = 1'b0;
            end
        end
    end

    // The decimal point is independent of blanking.
    assign w_cur_glyph = (i_lz_suppress && w_cur_lz) ? SEG_BLANK : f_encode(w_cur_code);
    assign w_seg_next  = {~w_cur_dp, w_cur_glyph};

    // ------------------------------------------------------------------------
    // Sequential state
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_presc         <= '0;
            r_idx           <= '0;
            r_shadow_digits <= '0;
            r_shadow_dp     <= '0;
            r_pending       <= 1'b0;
            r_active_digits <= '0;
            r_active_dp     <= '0;
            r_seg           <= 8'hFF;
            r_an            <= '1;
            r_scan_done     <= 1'b0;
        end else begin
            r_presc <= w_presc_tc ? '0 : r_presc + PRESC_W'(1);

            if (w_presc_tc) begin
                r_idx <= w_frame_end ? '0 : r_idx + IDX_W'(1);
            end

            r_scan_done <= w_frame_end;

            // On a boundary the shadow contents as of before this edge go
            // live; a load on the same edge lands in the shadow for the next
            // frame.
            if (w_frame_end && r_pending) begin
                r_active_digits <= r_shadow_digits;
                r_active_dp     <= r_shadow_dp;
            end

            if (i_load) begin
                r_shadow_digits <= i_digits_in;
                r_shadow_dp     <= i_dp_in;
                r_pending       <= 1'b1;
            end else if (w_frame_end) begin
                r_pending <= 1'b0;
            end

            // Outputs follow r_idx with one cycle of latency.
            r_seg <= w_seg_next;
            r_an  <= w_an_next;
        end
    end

    assign o_seg_out   = r_seg;
    assign o_an_out    = r_an;
    assign o_scan_done = r_scan_done;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// ----------------------------------------------------------------------------
// tb_seven_seg_scan_driver
//
// Directed bench for seven_seg_scan_driver with NUM_DIGITS=4, REFRESH_DIV=4
// (16-cycle frames). Outputs are sampled 1 time unit after each rising edge.
// cyc counts rising edges since reset release, so a frame boundary pulse is
// visible whenever cyc is a multiple of 16.
// ----------------------------------------------------------------------------
module tb_seven_seg_scan_driver;

    localparam int unsigned ND = 4;
    localparam int unsigned RD = 4;
    localparam int FRAME = ND * RD;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic [15:0] digits;
    logic [3:0]  dp;
    logic        lz;
    logic [7:0]  seg;
    logic [3:0]  an;
    logic        done;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    seven_seg_scan_driver #(
        .NUM_DIGITS  (ND),
        .REFRESH_DIV (RD)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_load        (load),
        .i_digits_in   (digits),
        .i_dp_in       (dp),
        .i_lz_suppress (lz),
        .o_seg_out     (seg),
        .o_an_out      (an),
        .o_scan_done   (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        rst    = 1'b1;
        load   = 1'b0;
        digits = 16'h0000;
        dp     = 4'b0000;
        lz     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (seg !== 8'hFF) begin
            bad++;
            $display("FAIL reset_seg got=%h exp=ff", seg);
        end
        total++;
        if (an !== 4'b1111) begin
            bad++;
            $display("FAIL reset_an got=%b exp=1111", an);
        end
        total++;
        if (done !== 1'b0) begin
            bad++;
            $display("FAIL reset_done got=%b exp=0", done);
        end
        @(negedge clk);
        rst = 1'b0;
        cyc = 0;
    endtask

    // Two frames of zeros, checking anode stepping and the frame pulse.
    task automatic test_idle_scan();
        int d;
        logic [3:0] ea;
        logic ed;
        for (int c = 0; c < 2 * FRAME; c++) begin
            tick();
            d  = (c % FRAME) / RD;
            ea = ~(4'b0001 << d);
            ed = ((cyc % FRAME) == 0);
            total++;
            if (seg !== 8'hC0) begin
                bad++;
                $display("FAIL idle_seg cyc=%0d got=%h exp=c0", cyc, seg);
            end
            total++;
            if (an !== ea) begin
                bad++;
                $display("FAIL idle_an cyc=%0d got=%b exp=%b", cyc, an, ea);
            end
            total++;
            if (done !== ed) begin
                bad++;
                $display("FAIL idle_done cyc=%0d got=%b exp=%b", cyc, done, ed);
            end
        end
    endtask

    // Mid-frame load: zeros persist until the boundary, then 1234 with dp2.
    task automatic test_load();
        logic [7:0] e [4];
        logic [3:0] ea;
        int d;
        e[0] = 8'h99; e[1] = 8'hB0; e[2] = 8'h24; e[3] = 8'hF9;
        for (int c = 0; c < FRAME; c++) begin
            if (c == 5) begin
                digits = 16'h1234;
                dp     = 4'b0100;
                load   = 1'b1;
            end
            tick();
            load = 1'b0;
            total++;
            if (seg !== 8'hC0) begin
                bad++;
                $display("FAIL load_old_seg cyc=%0d got=%h exp=c0", cyc, seg);
            end
        end
        for (int c = 0; c < FRAME; c++) begin
            tick();
            d  = c / RD;
            ea = ~(4'b0001 << d);
            total++;
            if (seg !== e[d]) begin
                bad++;
                $display("FAIL load_new_seg cyc=%0d digit=%0d got=%h exp=%h", cyc, d, seg, e[d]);
            end
            total++;
            if (an !== ea) begin
                bad++;
                $display("FAIL load_new_an cyc=%0d got=%b exp=%b", cyc, an, ea);
            end
        end
    endtask

    // Two loads in one frame: last wins, the first never appears.
    task automatic test_back_to_back();
        logic [7:0] eo [4];
        logic [7:0] en [4];
        int d;
        eo[0] = 8'h99; eo[1] = 8'hB0; eo[2] = 8'h24; eo[3] = 8'hF9;
        en[0] = 8'h80; en[1] = 8'hF8; en[2] = 8'h82; en[3] = 8'h92;
        for (int c = 0; c < FRAME; c++) begin
            if (c == 2) begin
                digits = 16'h1111;
                dp     = 4'b1111;
                load   = 1'b1;
            end
            if (c == 6) begin
                digits = 16'h5678;
                dp     = 4'b0000;
                load   = 1'b1;
            end
            tick();
            load = 1'b0;
            d = c / RD;
            total++;
            if (seg !== eo[d]) begin
                bad++;
                $display("FAIL b2b_old_seg cyc=%0d digit=%0d got=%h exp=%h", cyc, d, seg, eo[d]);
            end
        end
        for (int c = 0; c < 2 * FRAME; c++) begin
            tick();
            d = (c % FRAME) / RD;
            total++;
            if (seg !== en[d]) begin
                bad++;
                $display("FAIL b2b_new_seg cyc=%0d digit=%0d got=%h exp=%h", cyc, d, seg, en[d]);
            end
        end
    endtask

    // Load on the boundary edge: old shadow goes live, new one waits a frame.
    task automatic test_boundary_load();
        logic [7:0] e0 [4];
        logic [7:0] e1 [4];
        logic [7:0] e2 [4];
        logic ed;
        int d;
        e0[0] = 8'h80; e0[1] = 8'hF8; e0[2] = 8'h82; e0[3] = 8'h92;
        e1[0] = 8'hA4; e1[1] = 8'hA4; e1[2] = 8'hA4; e1[3] = 8'hA4;
        e2[0] = 8'hF9; e2[1] = 8'hA4; e2[2] = 8'hB0; e2[3] = 8'h99;
        for (int c = 0; c < FRAME; c++) begin
            if (c == 4) begin
                digits = 16'h2222;
                dp     = 4'b0000;
                load   = 1'b1;
            end
            if (c == FRAME - 1) begin
                digits = 16'h4321;
                dp     = 4'b0000;
                load   = 1'b1;
            end
            tick();
            load = 1'b0;
            d = c / RD;
            total++;
            if (seg !== e0[d]) begin
                bad++;
                $display("FAIL bnd_pre_seg cyc=%0d digit=%0d got=%h exp=%h", cyc, d, seg, e0[d]);
            end
        end
        for (int c = 0; c < FRAME; c++) begin
            tick();
            d  = c / RD;
            ed = (c == FRAME - 1);
            total++;
            if (seg !== e1[d]) begin
                bad++;
                $display("FAIL bnd_mid_seg cyc=%0d digit=%0d got=%h exp=%h", cyc, d, seg, e1[d]);
            end
            total++;
            if (done !== ed) begin
                bad++;
                $display("FAIL bnd_done cyc=%0d got=%b exp=%b", cyc, done, ed);
            end
        end
        for (int c = 0; c < FRAME; c++) begin
            tick();
            d = c / RD;
            total++;
            if (seg !== e2[d]) begin
                bad++;
                $display("FAIL bnd_post_seg cyc=%0d digit=%0d got=%h exp=%h", cyc, d, seg, e2[d]);
            end
        end
    endtask

    // Leading-zero suppression, unbuffered lz, and dp on a blanked digit.
    task automatic test_lz_suppress();
        logic [7:0] ea [4];
        logic [7:0] eb [4];
        logic [7:0] ec [4];
        int d;
        ea[0] = 8'hC0; ea[1] = 8'hF8; ea[2] = 8'hFF; ea[3] = 8'hFF;
        eb[0] = 8'hC0; eb[1] = 8'hF8; eb[2] = 8'hC0; eb[3] = 8'hC0;
        ec[0] = 8'hC0; ec[1] = 8'hFF; ec[2] = 8'hFF; ec[3] = 8'h7F;
        digits = 16'h0070;
        dp     = 4'b0000;
        lz     = 1'b1;
        load   = 1'b1;
        tick();
        load = 1'b0;
        repeat (FRAME - 1) tick();
        for (int c = 0; c < FRAME; c++) begin
            tick();
            d = c / RD;
            total++;
            if (seg !== ea[d]) begin
                bad++;
                $display("FAIL lz_on_seg cyc=%0d digit=%0d got=%h exp=%h", cyc, d, seg, ea[d]);
            end
        end
        lz = 1'b0;
        for (int c = 0; c < FRAME; c++) begin
            tick();
            d = c / RD;
            total++;
            if (seg !== eb[d]) begin
                bad++;
                $display("FAIL lz_off_seg cyc=%0d digit=%0d got=%h exp=%h", cyc, d, seg, eb[d]);
            end
        end
        digits = 16'h0000;
        dp     = 4'b1000;
        lz     = 1'b1;
        load   = 1'b1;
        tick();
        load = 1'b0;
        repeat (FRAME - 1) tick();
        for (int c = 0; c < FRAME; c++) begin
            tick();
            d = c / RD;
            total++;
            if (seg !== ec[d]) begin
                bad++;
                $display("FAIL lz_zero_seg cyc=%0d digit=%0d got=%h exp=%h", cyc, d, seg, ec[d]);
            end
        end
    endtask

    // Codes 10-15: glyphs with the hex macro, blank without; always nonzero.
    task automatic test_hex_codes();
        logic [7:0] eh [4];
        logic [7:0] ez [4];
        int d;
`ifdef SEVEN_SEG_HEX_DIGITS_EN
        eh[0] = 8'hA1; eh[1] = 8'hC6; eh[2] = 8'h83; eh[3] = 8'h88;
        ez[2] = 8'h88;
`else
        eh[0] = 8'hFF; eh[1] = 8'hFF; eh[2] = 8'hFF; eh[3] = 8'hFF;
        ez[2] = 8'hFF;
`endif
        ez[0] = 8'hC0; ez[1] = 8'hC0; ez[3] = 8'hFF;
        digits = 16'hABCD;
        dp     = 4'b0000;
        lz     = 1'b0;
        load   = 1'b1;
        tick();
        load = 1'b0;
        repeat (FRAME - 1) tick();
        for (int c = 0; c < FRAME; c++) begin
            tick();
            d = c / RD;
            total++;
            if (seg !== eh[d]) begin
                bad++;
                $display("FAIL hex_seg cyc=%0d digit=%0d got=%h exp=%h", cyc, d, seg, eh[d]);
            end
        end
        digits = 16'h0A00;
        lz     = 1'b1;
        load   = 1'b1;
        tick();
        load = 1'b0;
        repeat (FRAME - 1) tick();
        for (int c = 0; c < FRAME; c++) begin
            tick();
            d = c / RD;
            total++;
            if (seg !== ez[d]) begin
                bad++;
                $display("FAIL hex_lz_seg cyc=%0d digit=%0d got=%h exp=%h", cyc, d, seg, ez[d]);
            end
        end
        lz = 1'b0;
    endtask

    // Reset mid-frame with a pending load: outputs clear at once, load lost.
    task automatic test_reset_mid_frame();
        logic [3:0] ea;
        logic ed;
        int d;
        for (int c = 0; c < 5; c++) begin
            if (c == 1) begin
                digits = 16'h9999;
                dp     = 4'b1111;
                load   = 1'b1;
            end
            tick();
            load = 1'b0;
        end
        rst = 1'b1;
        #1;
        total++;
        if (seg !== 8'hFF) begin
            bad++;
            $display("FAIL midrst_seg got=%h exp=ff", seg);
        end
        total++;
        if (an !== 4'b1111) begin
            bad++;
            $display("FAIL midrst_an got=%b exp=1111", an);
        end
        total++;
        if (done !== 1'b0) begin
            bad++;
            $display("FAIL midrst_done got=%b exp=0", done);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        cyc = 0;
        for (int c = 0; c < 2 * FRAME; c++) begin
            tick();
            d  = (c % FRAME) / RD;
            ea = ~(4'b0001 << d);
            ed = ((cyc % FRAME) == 0);
            total++;
            if (seg !== 8'hC0) begin
                bad++;
                $display("FAIL midrst_after_seg cyc=%0d got=%h exp=c0", cyc, seg);
            end
            total++;
            if (an !== ea) begin
                bad++;
                $display("FAIL midrst_after_an cyc=%0d got=%b exp=%b", cyc, an, ea);
            end
            total++;
            if (done !== ed) begin
                bad++;
                $display("FAIL midrst_after_done cyc=%0d got=%b exp=%b", cyc, done, ed);
            end
        end
    endtask

    initial begin
        test_reset();
        test_idle_scan();
        test_load();
        test_back_to_back();
        test_boundary_load();
        test_lz_suppress();
        test_hex_codes();
        test_reset_mid_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
